pulse_period_meter: RTL and testbench
=====================================

// Module: pulse_period_meter
// PURPOSE
//   Receive-side counterpart of the periodic pulse generator: measures the gap between
//   successive high samples of pulse_i and reports it as a tick count, so a generator
//   programmed with ticks=N reads back as ticks_o=N.
//   Used to check tick/strobe streams and recover their programmed rate.
//   Also flags lock (stable rate) and timeout (stream lost).
// PARAMETERS
//   SIZE   8   width of the gap counter and of ticks_o; max measurable gap 2^SIZE-1
// PORTS
//   clk_i      in   1      single clock, all state on rising edge
//   rst_i      in   1      asynchronous, active-high reset
//   clear_i    in   1      synchronous restart: return to IDLE, drop lock
//   pulse_i    in   1      synchronous pulse stream (sampled, not edge-detected)
//   ticks_o    out  SIZE   last measured gap (non-pulse cycles between two high samples)
//   valid_o    out  1      1-cycle strobe: ticks_o updated this cycle
//   locked_o   out  1      level: last two measurements equal
//   timeout_o  out  1      1-cycle strobe: gap exceeded 2^SIZE-1, measurement abandoned
// BEHAVIOUR
//   Reset: ticks_o=0, valid_o=0, locked_o=0, timeout_o=0, cnt=0, state=IDLE.
//   Gap counter cnt (SIZE bits): cleared on every pulse_i=1 sample, else +1, never wraps.
//   Pulse every N+1 cycles -> N gap cycles -> ticks_o=N; pulse_i held high -> ticks_o=0.
//   FSM states: IDLE, ARMED, TRACK, LOCKED.
//     IDLE   : pulse_i=1 -> ARMED (first reference pulse, no measurement).
//     ARMED  : pulse_i=1 -> TRACK; ticks_o<=cnt, valid_o=1.
//     TRACK  : pulse_i=1 -> ticks_o<=cnt, valid_o=1; LOCKED if cnt==ticks_o, else stay.
//     LOCKED : pulse_i=1 & cnt==ticks_o -> stay, valid_o=1;
//              pulse_i=1 & cnt!=ticks_o -> TRACK, ticks_o<=cnt, valid_o=1, locked_o falls.
//   Timeout: in ARMED/TRACK/LOCKED, cnt==2^SIZE-1 & pulse_i=0 -> IDLE, timeout_o=1,
//     locked_o=0, ticks_o keeps its last value, cnt held at 0.
//     A pulse arriving at cnt==2^SIZE-1 is a valid measurement (ticks_o=2^SIZE-1).
//   Latency: all outputs registered; valid_o/ticks_o/locked_o change 1 cycle after
//     the pulse_i sample that completes a gap.
//   locked_o is registered from the next state: high exactly while state==LOCKED.
//   clear_i has priority over pulse_i and timeout: -> IDLE, cnt=0, locked_o=0,
//     no valid_o/timeout_o strobe that cycle, ticks_o retained; same-cycle pulse ignored.
//   In IDLE cnt is held at 0; no timeout is raised from IDLE.
//   rst_i mid-measurement: all state and outputs to reset values immediately.
//   valid_o and timeout_o are never high in the same cycle.
// STRUCTURE
//   Package pulse_meter_pkg: typedef enum logic [1:0] {IDLE, ARMED, TRACK, LOCKED}
//     meter_state_t.
//   No sub-module: saturating gap counter, compare and FSM stay in one file.
//   Two processes: one always_ff for the registers, one always_comb for next state.
// TESTING
//   1 Generator stream, ticks=5 (pulse every 6 cyc): 1st pulse no valid_o;
//     2nd -> valid_o, ticks_o=5; 3rd -> locked_o=1.
//   2 pulse_i held high from cycle 0: valid_o from the 2nd sample on, ticks_o=0,
//     locked_o=1 after the 3rd sample.
//   3 Locked at 5, then period switched to 3: valid_o with ticks_o=3, locked_o=0
//     the same cycle; next gap of 3 -> locked_o=1.
//   4 SIZE=4: gap of 15 -> valid_o, ticks_o=15; then no pulse for 16 cycles ->
//     timeout_o for 1 cycle, locked_o=0, ticks_o stays 15, next pulse only re-arms.
//   5 clear_i and pulse_i high in the same cycle while LOCKED: no valid_o, locked_o=0,
//     IDLE; next pulse re-arms; the one after gives valid_o.
//   6 rst_i asserted mid-gap, asynchronous to clk_i: all outputs 0 before the next edge;
//     after release, behaves as after power-up.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared types for the pulse period meter: FSM state encoding.
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } meter_state_t;

endpackage

// File: rtl/pulse_period_meter.sv
// Measures the gap (non-pulse cycles) between successive high samples of pulse_i,
// flags lock when two consecutive gaps match and timeout when the stream is lost.
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned SIZE = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            pulse_i,
    output logic [SIZE-1:0] ticks_o,
    output logic            valid_o,
    output logic            locked_o,
    output logic            timeout_o
);

    localparam logic [SIZE-1:0] CNT_MAX = '1;

    meter_state_t    state_q, state_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0] ticks_q, ticks_d;
    logic            valid_q, valid_d;
    logic            timeout_q, timeout_d;
    logic            locked_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ticks_d   = ticks_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;

        if (clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            // First pulse is only a reference point; nothing measured yet.
            cnt_d = '0;
            if (pulse_i) begin
                state_d = ARMED;
            end
        end else if (pulse_i) begin
            cnt_d   = '0;
            ticks_d = cnt_q;
            valid_d = 1'b1;
            case (state_q)
                ARMED:         state_d = TRACK;
                TRACK, LOCKED: state_d = (cnt_q == ticks_q) ? LOCKED : TRACK;
                default:       state_d = IDLE;
            endcase
        end else if (cnt_q == CNT_MAX) begin
            // Gap longer than the counter can express: abandon, keep last ticks.
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ticks_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ticks_q   <= ticks_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            locked_q  <= (state_d == LOCKED);
        end
    end

    assign ticks_o   = ticks_q;
    assign valid_o   = valid_q;
    assign locked_o  = locked_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter: SIZE=8 and SIZE=4 instances,
// per-cycle expectations queued at drive time and compared after each edge.
module tb_pulse_period_meter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr8 = 1'b0, pls8 = 1'b0;
    logic       clr4 = 1'b0, pls4 = 1'b0;
    logic [7:0] ticks8;
    logic [3:0] ticks4;
    logic       valid8, locked8, timeout8;
    logic       valid4, locked4, timeout4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit sel4;
        bit v;
        int t;
        bit l;
        bit to;
    } exp_t;

    exp_t sb[$];
    bit   use4 = 1'b0;

    pulse_period_meter #(.SIZE(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr8), .pulse_i(pls8),
        .ticks_o(ticks8), .valid_o(valid8), .locked_o(locked8), .timeout_o(timeout8)
    );

    pulse_period_meter #(.SIZE(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr4), .pulse_i(pls4),
        .ticks_o(ticks4), .valid_o(valid4), .locked_o(locked4), .timeout_o(timeout4)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic drv(input bit p, input bit c, input bit v, input int t,
                       input bit l, input bit to);
        exp_t e;
        @(negedge clk);
        if (use4) begin
            pls4 = p; clr4 = c;
        end else begin
            pls8 = p; clr8 = c;
        end
        e.sel4 = use4; e.v = v; e.t = t; e.l = l; e.to = to;
        sb.push_back(e);
    endtask

    task automatic gap(input int n, input int t, input bit l);
        for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, t, l, 1'b0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel4) begin
                    check_val("valid4",   int'(valid4),   int'(e.v));
                    check_val("ticks4",   int'(ticks4),   e.t);
                    check_val("locked4",  int'(locked4),  int'(e.l));
                    check_val("timeout4", int'(timeout4), int'(e.to));
                end else begin
                    check_val("valid8",   int'(valid8),   int'(e.v));
                    check_val("ticks8",   int'(ticks8),   e.t);
                    check_val("locked8",  int'(locked8),  int'(e.l));
                    check_val("timeout8", int'(timeout8), int'(e.to));
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_val("rst_ticks8",  int'(ticks8),  0);
        check_val("rst_valid8",  int'(valid8),  0);
        check_val("rst_locked8", int'(locked8), 0);
        check_val("rst_tmo8",    int'(timeout8), 0);
        check_val("rst_ticks4",  int'(ticks4),  0);

        // Period 6 (gap 5): arm, measure, lock, stay locked.
        use4 = 1'b0;
        drv(1, 0, 0, 0, 0, 0);
        gap(5, 0, 0);
        drv(1, 0, 1, 5, 0, 0);
        gap(5, 5, 0);
        drv(1, 0, 1, 5, 1, 0);
        gap(5, 5, 1);
        drv(1, 0, 1, 5, 1, 0);
        // Switch to gap 3: lock drops with the new value, regained next gap.
        gap(3, 5, 1);
        drv(1, 0, 1, 3, 0, 0);
        gap(3, 3, 0);
        drv(1, 0, 1, 3, 1, 0);
        // clear with a same-cycle pulse while locked.
        gap(2, 3, 1);
        drv(1, 1, 0, 3, 0, 0);
        gap(2, 3, 0);
        drv(1, 0, 0, 3, 0, 0);
        gap(4, 3, 0);
        drv(1, 0, 1, 4, 0, 0);
        gap(2, 4, 0);

        // Asynchronous reset mid-gap: outputs drop before the next edge.
        while (sb.size() > 0) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("arst_ticks8",  int'(ticks8),  0);
        check_val("arst_valid8",  int'(valid8),  0);
        check_val("arst_locked8", int'(locked8), 0);
        check_val("arst_tmo8",    int'(timeout8), 0);
        @(negedge clk);
        pls8 = 1'b0;
        rst = 1'b0;

        // pulse_i held high: every sample after the first is a zero-length gap.
        drv(1, 0, 0, 0, 0, 0);
        drv(1, 0, 1, 0, 0, 0);
        drv(1, 0, 1, 0, 1, 0);
        drv(1, 0, 1, 0, 1, 0);
        drv(0, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0);

        // SIZE=4: maximum gap, then timeouts from TRACK and from LOCKED.
        use4 = 1'b1;
        drv(1, 0, 0, 0, 0, 0);
        gap(15, 0, 0);
        drv(1, 0, 1, 15, 0, 0);
        gap(15, 15, 0);
        drv(0, 0, 0, 15, 0, 1);
        gap(20, 15, 0);
        drv(1, 0, 0, 15, 0, 0);
        gap(3, 15, 0);
        drv(1, 0, 1, 3, 0, 0);
        gap(3, 3, 0);
        drv(1, 0, 1, 3, 1, 0);
        gap(15, 3, 1);
        drv(0, 0, 0, 3, 0, 1);
        gap(2, 3, 0);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        check_val("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
